// File: rtl/link_chk_pkg.sv
// Constants and state encoding shared by the link checker and the sender-side pattern generator.
// No logic; pure declarations.
package link_chk_pkg;

  localparam int                     LINK_DATA_W = 32;
  localparam logic [LINK_DATA_W-1:0] LINK_SEED   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_e;

endpackage

// File: rtl/link_data_checker_if.sv
// Receive-side link bundle: word, one-cycle valid strobe and sender-done level.
// Master drives (link receiver), slave consumes (checker); no backpressure path.
interface link_data_checker_if
  import link_chk_pkg::*;
#(
  parameter int DATA_W = LINK_DATA_W
);

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              send_done;

  modport master (output data_in, data_valid, send_done);
  modport slave  (input  data_in, data_valid, send_done);

endinterface

// File: rtl/link_chk_pattern.sv
// Expected-value register of the decrementing test pattern: load to seed, step down, or resync.
// Updates 1 cycle after the control strobe; no backpressure.
module link_chk_pattern
  import link_chk_pkg::*;
#(
  parameter int                DATA_W = LINK_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(LINK_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              resync,
  input  logic [DATA_W-1:0] resync_val,
  output logic [DATA_W-1:0] expected
);

  // Subtraction wraps naturally, so 0 steps to all-ones.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      expected <= SEED;
    end else if (step) begin
      if (resync) begin
        expected <= resync_val - DATA_W'(1);
      end else begin
        expected <= expected - DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/link_data_checker.sv
// Checks received link words against the decrementing pattern; counts words/errors, flags pass/fail.
// Results 1 cycle after data_valid, led 1 cycle later; no backpressure. Option: LINK_CHK_RESYNC_EN.
module link_data_checker
  import link_chk_pkg::*;
#(
  parameter int                DATA_W       = LINK_DATA_W,
  parameter int                EXPECT_COUNT = 100,
  parameter logic [DATA_W-1:0] SEED         = DATA_W'(LINK_SEED),
  parameter int                ERR_W        = 16,
  parameter int                CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  link_data_checker_if.slave    link,
  output logic                  led,
  output logic                  pass,
  output logic                  fail,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_count,
  output logic [ERR_W-1:0]      err_count,
  output logic [DATA_W-1:0]     first_err_data
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_CHECK = 2'(CHECK);
  localparam logic [1:0] ST_PASS  = 2'(PASS);
  localparam logic [1:0] ST_FAIL  = 2'(FAIL);

  localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(EXPECT_COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXPECT_COUNT - 1);

  logic [1:0]        state;
  logic [DATA_W-1:0] expected;
  logic              accept;
  logic              mismatch;
  logic              last_word;
  logic              resync;

  assign accept    = (state == ST_CHECK) && link.data_valid;
  assign mismatch  = (link.data_in != expected);
  assign last_word = (word_count == LAST_CNT);

`ifdef LINK_CHK_RESYNC_EN
  // Realign to the received word so one corrupted word costs a single error.
  assign resync = mismatch;
`else
  assign resync = 1'b0;
`endif

  link_chk_pattern #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .clk        (clk),
    .rst        (rst),
    .load       (!en || (state == ST_IDLE)),
    .step       (accept && en),
    .resync     (resync),
    .resync_val (link.data_in),
    .expected   (expected)
  );

  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);
  assign busy = (state == ST_CHECK);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state          <= ST_IDLE;
      word_count     <= '0;
      err_count      <= '0;
      first_err_data <= '0;
      led            <= 1'b0;
    end else begin
      led <= (state == ST_PASS);
      case (state)
        ST_IDLE: begin
          word_count     <= '0;
          err_count      <= '0;
          first_err_data <= '0;
          state          <= ST_CHECK;
        end
        ST_CHECK: begin
          if (link.data_valid) begin
            word_count <= word_count + CNT_W'(1);
            if (mismatch) begin
              if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
              end
              if (err_count == '0) begin
                first_err_data <= link.data_in;
              end
            end
            // A word arriving with send_done is counted first; finishing on it is not a short burst.
            if (last_word) begin
              state <= ((err_count == '0) && !mismatch) ? ST_PASS : ST_FAIL;
            end
          end else if (link.send_done && (word_count < EXP_CNT)) begin
            state <= ST_FAIL;
          end
        end
        ST_PASS: begin
          if (link.data_valid) begin
            state <= ST_FAIL;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_data_checker.sv
// Scoreboarded directed bench for link_data_checker: a 100-word instance and a 3-word wrap instance.
module tb_link_data_checker;

  localparam int F_PASS = 0;
  localparam int F_FAIL = 1;
  localparam int F_BUSY = 2;
  localparam int F_LED  = 3;
  localparam int F_WC   = 4;
  localparam int F_EC   = 5;
  localparam int F_FED  = 6;

`ifdef LINK_CHK_RESYNC_EN
  localparam logic [31:0] CORRUPT_ERRS = 32'd1;
`else
  localparam logic [31:0] CORRUPT_ERRS = 32'd90;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_a, en_b;
  logic led_a, pass_a, fail_a, busy_a;
  logic led_b, pass_b, fail_b, busy_b;
  logic [15:0] wc_a, ec_a, wc_b, ec_b;
  logic [31:0] fed_a, fed_b;

  link_data_checker_if #(.DATA_W(32)) la ();
  link_data_checker_if #(.DATA_W(32)) lb ();

  link_data_checker #(
    .DATA_W(32), .EXPECT_COUNT(100), .SEED(32'hFFFF_FFFF), .ERR_W(16), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .link(la),
    .led(led_a), .pass(pass_a), .fail(fail_a), .busy(busy_a),
    .word_count(wc_a), .err_count(ec_a), .first_err_data(fed_a)
  );

  link_data_checker #(
    .DATA_W(32), .EXPECT_COUNT(3), .SEED(32'h0000_0001), .ERR_W(16), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .link(lb),
    .led(led_b), .pass(pass_b), .fail(fail_b), .busy(busy_b),
    .word_count(wc_b), .err_count(ec_b), .first_err_data(fed_b)
  );

  typedef struct {
    int          due;
    int          dut;
    int          fld;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fname(input int f);
    case (f)
      F_PASS:  return "pass";
      F_FAIL:  return "fail";
      F_BUSY:  return "busy";
      F_LED:   return "led";
      F_WC:    return "word_count";
      F_EC:    return "err_count";
      default: return "first_err_data";
    endcase
  endfunction

  function automatic logic [31:0] get_field(input int d, input int f);
    logic [31:0] r;
    r = '0;
    case (f)
      F_PASS:  r = {31'b0, (d == 0) ? pass_a : pass_b};
      F_FAIL:  r = {31'b0, (d == 0) ? fail_a : fail_b};
      F_BUSY:  r = {31'b0, (d == 0) ? busy_a : busy_b};
      F_LED:   r = {31'b0, (d == 0) ? led_a  : led_b};
      F_WC:    r = {16'b0, (d == 0) ? wc_a   : wc_b};
      F_EC:    r = {16'b0, (d == 0) ? ec_a   : ec_b};
      default: r = (d == 0) ? fed_a : fed_b;
    endcase
    return r;
  endfunction

  task automatic expect_val(input int d, input int f, input logic [31:0] v, input int delay);
    exp_t e;
    e.due = cyc + delay;
    e.dut = d;
    e.fld = f;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input int d, input int delay);
    for (int f = F_PASS; f <= F_FED; f++) expect_val(d, f, 32'd0, delay);
  endtask

  // Monitor: compares every scoreboard entry whose cycle has come, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] got;
        got = get_field(sb[i].dut, sb[i].fld);
        checks++;
        if ((sb[i].due < cyc) || (got !== sb[i].exp)) begin
          errors++;
          $display("FAIL %s dut%0d cyc=%0d: got %h, expected %h", fname(sb[i].fld), sb[i].dut,
                   cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic sd, input logic e,
                       input logic r);
    @(posedge clk);
    #1;
    la.data_valid = v;
    la.data_in    = d;
    la.send_done  = sd;
    en_a          = e;
    rst           = r;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic e);
    @(posedge clk);
    #1;
    lb.data_valid = v;
    lb.data_in    = d;
    en_b          = e;
  endtask

  task automatic start_run();
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    expect_val(0, F_BUSY, 32'd1, 1);
  endtask

  task automatic stop_run();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    expect_zero(0, 1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clean_run();
    start_run();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'hFFFF_FFFF - 32'(i), (i == 99), 1'b1, 1'b0);
      if (i == 0) expect_val(0, F_WC, 32'd1, 1);
    end
    expect_val(0, F_PASS, 32'd1, 1);
    expect_val(0, F_FAIL, 32'd0, 1);
    expect_val(0, F_BUSY, 32'd0, 1);
    expect_val(0, F_WC, 32'd100, 1);
    expect_val(0, F_EC, 32'd0, 1);
    expect_val(0, F_FED, 32'd0, 1);
    expect_val(0, F_LED, 32'd0, 1);
    expect_val(0, F_LED, 32'd1, 2);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    expect_val(0, F_PASS, 32'd1, 1);
    stop_run();
  endtask

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    la.data_valid = 1'b0; la.data_in = '0; la.send_done = 1'b0;
    lb.data_valid = 1'b0; lb.data_in = '0; lb.send_done = 1'b0;

    repeat (3) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    expect_zero(0, 1);
    expect_zero(1, 1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    clean_run();

    // Corruption: word index 10 becomes 0x12345678 and the sender carries on from there.
    start_run();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, (i < 10) ? 32'hFFFF_FFFF - 32'(i) : 32'h1234_5678 - 32'(i - 10), 1'b0,
            1'b1, 1'b0);
      if (i == 10) begin
        expect_val(0, F_EC, 32'd1, 1);
        expect_val(0, F_FED, 32'h1234_5678, 1);
      end
    end
    expect_val(0, F_FAIL, 32'd1, 1);
    expect_val(0, F_PASS, 32'd0, 1);
    expect_val(0, F_EC, CORRUPT_ERRS, 1);
    expect_val(0, F_FED, 32'h1234_5678, 1);
    expect_val(0, F_WC, 32'd100, 1);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    stop_run();

    // Short burst: 60 words, then send_done alone.
    start_run();
    for (int i = 0; i < 60; i++) drive(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0, 1'b1, 1'b0);
    expect_val(0, F_BUSY, 32'd1, 1);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    expect_val(0, F_FAIL, 32'd1, 1);
    expect_val(0, F_BUSY, 32'd0, 1);
    expect_val(0, F_WC, 32'd60, 1);
    expect_val(0, F_EC, 32'd0, 1);
    stop_run();

    // Overrun: 101 back-to-back words.
    start_run();
    for (int i = 0; i < 101; i++) begin
      drive(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0, 1'b1, 1'b0);
      if (i == 99) expect_val(0, F_PASS, 32'd1, 1);
      if (i == 100) begin
        expect_val(0, F_PASS, 32'd0, 1);
        expect_val(0, F_FAIL, 32'd1, 1);
      end
    end
    stop_run();

    // Abort by reset at word 50, then a clean run.
    start_run();
    for (int i = 0; i < 50; i++) drive(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hFFFF_FFCD, 1'b0, 1'b1, 1'b1);
    expect_zero(0, 1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    clean_run();

    // Abort by en=0 at word 50, then a clean run.
    start_run();
    for (int i = 0; i < 50; i++) drive(1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hFFFF_FFCD, 1'b0, 1'b0, 1'b0);
    expect_zero(0, 1);
    clean_run();

    // Wrap through zero on the small instance: 1, 0, 0xFFFFFFFF.
    drive_b(1'b0, 32'd0, 1'b1);
    expect_val(1, F_BUSY, 32'd1, 1);
    drive_b(1'b1, 32'h0000_0001, 1'b1);
    drive_b(1'b1, 32'h0000_0000, 1'b1);
    drive_b(1'b1, 32'hFFFF_FFFF, 1'b1);
    expect_val(1, F_PASS, 32'd1, 1);
    expect_val(1, F_FAIL, 32'd0, 1);
    expect_val(1, F_EC, 32'd0, 1);
    expect_val(1, F_WC, 32'd3, 1);
    drive_b(1'b0, 32'd0, 1'b1);
    checks++;
    if (pass_b !== 1'b1) begin
      errors++;
      $display("FAIL wrap pass: got %b, expected 1", pass_b);
    end
    checks++;
    if (fail_b !== 1'b0) begin
      errors++;
      $display("FAIL wrap fail: got %b, expected 0", fail_b);
    end
    checks++;
    if (wc_b !== 16'd3) begin
      errors++;
      $display("FAIL wrap word_count: got %0d, expected 3", wc_b);
    end
    checks++;
    if (ec_b !== 16'd0) begin
      errors++;
      $display("FAIL wrap err_count: got %0d, expected 0", ec_b);
    end
    expect_val(1, F_LED, 32'd1, 1);
    drive_b(1'b0, 32'd0, 1'b0);
    expect_zero(1, 1);

    repeat (4) drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d never compared, expected %h", fname(sb[0].fld), sb[0].dut,
               sb[0].exp);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
